// File: rtl/rs_alu_queue_if.sv
// ALU reservation-station types and port bundle.
// Dispatch, wakeup and issue signals live on one interface.
package rs_alu_pkg;
  localparam int PRF_W = 6;

  typedef logic [PRF_W-1:0] prf_t;

  typedef struct packed {
    logic [7:0] opcode;
    prf_t       pdest;
    prf_t       op0PAddr;
    prf_t       op1PAddr;
  } uop_t;
endpackage

interface rs_alu_queue_if
  import rs_alu_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WK_PORTS = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                      flush;
  logic                      wen_0;
  logic                      wen_1;
  uop_t                      din_0;
  uop_t                      din_1;
  logic                      din_0_rdy0;
  logic                      din_0_rdy1;
  logic                      din_1_rdy0;
  logic                      din_1_rdy1;
  logic [WK_PORTS-1:0]       wk_valid;
  logic [WK_PORTS-1:0][PRF_W-1:0] wk_prf;
  logic                      issue_valid;
  uop_t                      issue_uop;
  logic                      issue_ready;
  logic                      almost_full;
  logic [CW-1:0]             count;

  modport master (
    output flush, wen_0, wen_1, din_0, din_1,
    output din_0_rdy0, din_0_rdy1,
    output din_1_rdy0, din_1_rdy1,
    output wk_valid, wk_prf, issue_ready,
    input  issue_valid, issue_uop,
    input  almost_full, count
  );

  modport slave (
    input  flush, wen_0, wen_1, din_0, din_1,
    input  din_0_rdy0, din_0_rdy1,
    input  din_1_rdy0, din_1_rdy1,
    input  wk_valid, wk_prf, issue_ready,
    output issue_valid, issue_uop,
    output almost_full, count
  );
endinterface

// File: rtl/rs_alu_queue.sv
// Age-ordered, compacting ALU reservation station.
// Oldest ready entry issues; younger entries shift down.
module rs_alu_queue
  import rs_alu_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WK_PORTS = 2
) (
  input logic          clk,
  input logic          rst_n,
  rs_alu_queue_if.slave io
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0] v_q, r0_q, r1_q;
  uop_t             u_q [DEPTH];
  logic [CW-1:0]    cnt_q;

  logic [DEPTH-1:0] v_d, r0_d, r1_d;
  uop_t             u_d [DEPTH];
  logic [CW-1:0]    cnt_d;

  logic [DEPTH:0]   wv, w0, w1;
  uop_t             wu [DEPTH+1];

  logic             sel_hit;
  logic [IW-1:0]    sel_idx;
  logic             issue;
  logic             e0, e1;
  logic [CW-1:0]    tail, tail1;

  function automatic logic hit(
    input prf_t                           t,
    input logic [WK_PORTS-1:0]            vv,
    input logic [WK_PORTS-1:0][PRF_W-1:0] tt
  );
    logic h;
    h = 1'b0;
    for (int p = 0; p < WK_PORTS; p++)
      if (vv[p] && tt[p] == t) h = 1'b1;
    return h;
  endfunction

  // pick the lowest-index entry with both operands ready
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v_q[i] && r0_q[i] && r1_q[i]) begin
        sel_hit = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  assign issue          = sel_hit & io.issue_ready;
  assign io.issue_valid = sel_hit;
  assign io.issue_uop   = sel_hit ? u_q[sel_idx] : '0;
  assign io.almost_full = cnt_q > CW'(DEPTH - 2);
  assign io.count       = cnt_q;

  assign e0    = io.wen_0 & ~io.almost_full;
  assign e1    = io.wen_1 & ~io.almost_full;
  assign tail  = cnt_q - CW'(issue);
  assign tail1 = tail + CW'(e0);

  // wake, shift out the issued slot, then append at new tail
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wv[i] = v_q[i];
      wu[i] = u_q[i];
      w0[i] = r0_q[i] |
              (v_q[i] & hit(u_q[i].op0PAddr, io.wk_valid, io.wk_prf));
      w1[i] = r1_q[i] |
              (v_q[i] & hit(u_q[i].op1PAddr, io.wk_valid, io.wk_prf));
    end
    wv[DEPTH] = 1'b0;
    w0[DEPTH] = 1'b0;
    w1[DEPTH] = 1'b0;
    wu[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue && i >= int'(sel_idx)) begin
        v_d[i]  = wv[i+1];
        r0_d[i] = w0[i+1];
        r1_d[i] = w1[i+1];
        u_d[i]  = wu[i+1];
      end else begin
        v_d[i]  = wv[i];
        r0_d[i] = w0[i];
        r1_d[i] = w1[i];
        u_d[i]  = wu[i];
      end
      if (e0 && CW'(i) == tail) begin
        v_d[i]  = 1'b1;
        u_d[i]  = io.din_0;
        r0_d[i] = io.din_0_rdy0 |
                  hit(io.din_0.op0PAddr, io.wk_valid, io.wk_prf);
        r1_d[i] = io.din_0_rdy1 |
                  hit(io.din_0.op1PAddr, io.wk_valid, io.wk_prf);
      end
      if (e1 && CW'(i) == tail1) begin
        v_d[i]  = 1'b1;
        u_d[i]  = io.din_1;
        r0_d[i] = io.din_1_rdy0 |
                  hit(io.din_1.op0PAddr, io.wk_valid, io.wk_prf);
        r1_d[i] = io.din_1_rdy1 |
                  hit(io.din_1.op1PAddr, io.wk_valid, io.wk_prf);
      end
    end
    cnt_d = tail + CW'(e0) + CW'(e1);
    if (io.flush) begin
      v_d   = '0;
      r0_d  = '0;
      r1_d  = '0;
      cnt_d = '0;
    end
  end

  // entry state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      r0_q  <= '0;
      r1_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) u_q[i] <= '0;
    end else begin
      v_q   <= v_d;
      r0_q  <= r0_d;
      r1_q  <= r1_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) u_q[i] <= u_d[i];
    end
  end
endmodule

// File: tb/tb_rs_alu_queue.sv
// Directed bench for rs_alu_queue.
// Hand-computed expectations for issue order and occupancy.
module tb_rs_alu_queue;
  import rs_alu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  rs_alu_queue_if #(.DEPTH(8), .WK_PORTS(2)) io ();

  rs_alu_queue #(.DEPTH(8), .WK_PORTS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic uop_t mk(input int id);
    uop_t u;
    u.opcode   = id[7:0];
    u.pdest    = id[5:0];
    u.op0PAddr = 6'(id + 32);
    u.op1PAddr = 6'(id);
    return u;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    io.flush      = 1'b0;
    io.wen_0      = 1'b0;
    io.wen_1      = 1'b0;
    io.din_0      = '0;
    io.din_1      = '0;
    io.din_0_rdy0 = 1'b0;
    io.din_0_rdy1 = 1'b0;
    io.din_1_rdy0 = 1'b0;
    io.din_1_rdy1 = 1'b0;
    io.wk_valid   = '0;
    io.wk_prf     = '0;
  endtask

  task automatic enq1(input int a);
    io.wen_0      = 1'b1;
    io.din_0      = mk(a);
    io.din_0_rdy0 = 1'b1;
    io.din_0_rdy1 = 1'b1;
    step();
    idle();
  endtask

  task automatic enq2(input int a, input int b);
    io.wen_0      = 1'b1;
    io.din_0      = mk(a);
    io.din_0_rdy0 = 1'b1;
    io.din_0_rdy1 = 1'b1;
    io.wen_1      = 1'b1;
    io.din_1      = mk(b);
    io.din_1_rdy0 = 1'b1;
    io.din_1_rdy1 = 1'b1;
    step();
    idle();
  endtask

  initial begin
    uop_t ua;
    uop_t uc;
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    io.issue_ready = 1'b0;
    idle();
    #1;
    chk("rst_valid", 64'(io.issue_valid), 64'd0);
    chk("rst_uop", 64'(io.issue_uop), 64'd0);
    chk("rst_count", 64'(io.count), 64'd0);
    chk("rst_af", 64'(io.almost_full), 64'd0);
    #21 rst_n = 1'b1;
    step();
    chk("post_rst_count", 64'(io.count), 64'd0);

    // dual enqueue, back-to-back issue
    io.issue_ready = 1'b1;
    enq2(1, 2);
    chk("dual_cnt2", 64'(io.count), 64'd2);
    chk("dual_v_a", 64'(io.issue_valid), 64'd1);
    chk("dual_uop_a", 64'(io.issue_uop), 64'(mk(1)));
    step();
    chk("dual_cnt1", 64'(io.count), 64'd1);
    chk("dual_uop_b", 64'(io.issue_uop), 64'(mk(2)));
    step();
    chk("dual_cnt0", 64'(io.count), 64'd0);
    chk("dual_v0", 64'(io.issue_valid), 64'd0);
    chk("dual_uop0", 64'(io.issue_uop), 64'd0);

    // younger ready entry bypasses a waiting older one
    io.issue_ready = 1'b0;
    ua          = mk(3);
    ua.op0PAddr = 6'd5;
    io.wen_0      = 1'b1;
    io.din_0      = ua;
    io.din_0_rdy0 = 1'b0;
    io.din_0_rdy1 = 1'b1;
    step();
    idle();
    chk("wk_cnt1", 64'(io.count), 64'd1);
    chk("wk_notready", 64'(io.issue_valid), 64'd0);
    enq1(4);
    chk("wk_b_sel", 64'(io.issue_uop), 64'(mk(4)));
    io.issue_ready = 1'b1;
    io.wk_valid    = 2'b01;
    io.wk_prf[0]   = 6'd5;
    step();
    idle();
    chk("wk_a_valid", 64'(io.issue_valid), 64'd1);
    chk("wk_a_uop", 64'(io.issue_uop), 64'(ua));
    chk("wk_cnt_after", 64'(io.count), 64'd1);
    step();
    chk("wk_drained", 64'(io.count), 64'd0);

    // enqueue-time wakeup bypass on operand 1
    io.issue_ready = 1'b0;
    uc = mk(5);
    io.wen_0      = 1'b1;
    io.din_0      = uc;
    io.din_0_rdy0 = 1'b1;
    io.din_0_rdy1 = 1'b0;
    io.wk_valid   = 2'b10;
    io.wk_prf[1]  = uc.op1PAddr;
    step();
    idle();
    chk("byp_valid", 64'(io.issue_valid), 64'd1);
    chk("byp_uop", 64'(io.issue_uop), 64'(uc));
    io.issue_ready = 1'b1;
    step();
    chk("byp_drained", 64'(io.count), 64'd0);

    // fill, issue+enqueue together, then drain in age order
    io.issue_ready = 1'b0;
    enq2(10, 11);
    enq2(12, 13);
    enq2(14, 15);
    chk("fill_cnt6", 64'(io.count), 64'd6);
    chk("fill_af0", 64'(io.almost_full), 64'd0);
    io.issue_ready = 1'b1;
    enq1(16);
    chk("swap_cnt", 64'(io.count), 64'd6);
    chk("swap_head", 64'(io.issue_uop), 64'(mk(11)));
    io.issue_ready = 1'b0;
    enq1(17);
    chk("fill_cnt7", 64'(io.count), 64'd7);
    chk("fill_af1", 64'(io.almost_full), 64'd1);
    io.issue_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("order_%0d", k),
          64'(io.issue_uop), 64'(mk(11 + k)));
      step();
    end
    chk("order_cnt0", 64'(io.count), 64'd0);
    chk("order_af0", 64'(io.almost_full), 64'd0);

    // flush beats a simultaneous enqueue
    io.issue_ready = 1'b0;
    enq2(20, 21);
    enq2(22, 23);
    enq1(24);
    chk("fl_cnt5", 64'(io.count), 64'd5);
    io.flush = 1'b1;
    enq1(25);
    chk("fl_cnt0", 64'(io.count), 64'd0);
    chk("fl_valid0", 64'(io.issue_valid), 64'd0);
    enq1(26);
    chk("fl_reuse", 64'(io.issue_uop), 64'(mk(26)));

    // asynchronous reset with occupied entries
    enq2(27, 28);
    enq2(29, 30);
    enq1(31);
    chk("ar_cnt6", 64'(io.count), 64'd6);
    chk("ar_valid1", 64'(io.issue_valid), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid0", 64'(io.issue_valid), 64'd0);
    chk("ar_uop0", 64'(io.issue_uop), 64'd0);
    chk("ar_cnt0", 64'(io.count), 64'd0);
    #12 rst_n = 1'b1;
    step();
    chk("ar_rel_cnt", 64'(io.count), 64'd0);
    chk("ar_rel_valid", 64'(io.issue_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
